// File: rtl/shop_ctrl.sv
// rtl/shop_ctrl.sv - shop/battle transaction sequencer driving the player stats block
module shop_ctrl #(
  parameter int NREQ         = 3,
  parameter int ROUND_INCOME = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_sell,
  input  logic [10*NREQ-1:0]  req_amt,
  output logic [NREQ-1:0]     req_ack,
  output logic                req_ok,
  input  logic                battle_valid,
  input  logic                battle_win,
  input  logic                battle_tie,
  output logic                battle_ack,
  input  logic [9:0]          coins,
  output logic [9:0]          cost,
  output logic [9:0]          revenue,
  output logic                battleDone,
  output logic                decr_lives,
  output logic                busy,
  output logic                game_over
);

  typedef enum logic [2:0] {IDLE, APPLY, BATTLE, INCOME, SETTLE, OVER} state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [1:0]        lives;
  logic              pulsed;
  logic              final_loss;

  logic              found;
  logic [1:0]        sel;
  logic [2:0]        cand;
  logic [NREQ-1:0]   sel_onehot;
  logic [9:0]        sel_amt;
  logic              sel_sell;
  logic [1:0]        next_ptr;
  logic [9:0]        headroom;
  logic [10:0]       sum11;
  logic [9:0]        sell_amt;
  logic [9:0]        income;
  logic              deny;
  logic              loss;

  // Round-robin search: first valid requester at or after rr_ptr
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'(NREQ))
        cand = cand - 3'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_valid[j] && (cand[1:0] == 2'(j))) begin
          found = 1'b1;
          sel   = 2'(j);
        end
      end
    end
  end

  // Pick out the selected requester's operation and amount
  always_comb begin
    sel_amt    = '0;
    sel_sell   = 1'b0;
    sel_onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (sel == 2'(j)) begin
        sel_amt       = req_amt[10*j +: 10];
        sel_sell      = req_sell[j];
        sel_onehot[j] = 1'b1;
      end
    end
  end

  // Sells clip at the 1023 ceiling; buys beyond the purse are denied
  assign headroom = 10'd1023 - coins;
  assign sum11    = {1'b0, coins} + {1'b0, sel_amt};
  assign sell_amt = (sum11 > 11'd1023) ? headroom : sel_amt;
  assign income   = (headroom < 10'(ROUND_INCOME)) ? headroom : 10'(ROUND_INCOME);
  assign deny     = !sel_sell && (sel_amt > coins);
  assign loss     = !battle_win && !battle_tie;
  assign next_ptr = (sel == 2'(NREQ-1)) ? 2'd0 : sel + 2'd1;
  assign busy     = (state != IDLE);

  // Sequencer: every pulse output is registered and cleared the cycle after it is set
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lives      <= 2'd3;
      pulsed     <= 1'b0;
      final_loss <= 1'b0;
      req_ack    <= '0;
      req_ok     <= 1'b0;
      battle_ack <= 1'b0;
      cost       <= '0;
      revenue    <= '0;
      battleDone <= 1'b0;
      decr_lives <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      req_ack    <= '0;
      req_ok     <= 1'b0;
      battle_ack <= 1'b0;
      cost       <= '0;
      revenue    <= '0;
      battleDone <= 1'b0;
      decr_lives <= 1'b0;
      case (state)
        IDLE: begin
          if (battle_valid) begin
            state      <= BATTLE;
            battleDone <= 1'b1;
            battle_ack <= 1'b1;
            final_loss <= loss && (lives == 2'd1);
            if (loss) begin
              decr_lives <= 1'b1;
              lives      <= lives - 2'd1;
            end
          end else if (found) begin
            state   <= APPLY;
            req_ack <= sel_onehot;
            rr_ptr  <= next_ptr;
            if (deny) begin
              pulsed <= 1'b0;
            end else begin
              req_ok <= 1'b1;
              if (sel_sell) begin
                revenue <= sell_amt;
                pulsed  <= (sell_amt != 10'd0);
              end else begin
                cost   <= sel_amt;
                pulsed <= (sel_amt != 10'd0);
              end
            end
          end
        end
        APPLY:  state <= pulsed ? SETTLE : IDLE;
        BATTLE: begin
          if (final_loss) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state   <= INCOME;
            revenue <= income;
          end
        end
        INCOME: state <= SETTLE;
        SETTLE: state <= IDLE;
        OVER: begin
          // Skip the cycle right after an ack so a requester dropping valid is not acked twice
          if ((req_ack == '0) && !battle_ack) begin
            if (battle_valid) begin
              battle_ack <= 1'b1;
            end else if (found) begin
              req_ack <= sel_onehot;
              rr_ptr  <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shop_ctrl.sv
// tb/tb_shop_ctrl.sv - randomized and directed checks of shop_ctrl against a timeline model
module tb_shop_ctrl;

  localparam int NREQ = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_sell;
  logic [10*NREQ-1:0] req_amt;
  logic [NREQ-1:0]    req_ack;
  logic               req_ok;
  logic               battle_valid;
  logic               battle_win;
  logic               battle_tie;
  logic               battle_ack;
  logic [9:0]         coins;
  logic [9:0]         cost;
  logic [9:0]         revenue;
  logic               battleDone;
  logic               decr_lives;
  logic               busy;
  logic               game_over;

  logic               coins_load;
  logic [9:0]         coins_load_val;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cnt_decr = 0;
  int cnt_inc  = 0;
  bit rnd_on  = 1'b0;
  int rst_cnt = 0;

  always #5 clk = ~clk;

  shop_ctrl #(.NREQ(NREQ), .ROUND_INCOME(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sell(req_sell), .req_amt(req_amt),
    .req_ack(req_ack), .req_ok(req_ok),
    .battle_valid(battle_valid), .battle_win(battle_win), .battle_tie(battle_tie),
    .battle_ack(battle_ack), .coins(coins), .cost(cost), .revenue(revenue),
    .battleDone(battleDone), .decr_lives(decr_lives), .busy(busy), .game_over(game_over)
  );

  // Stand-in for the stats block: coin count follows the pulses one edge later
  always @(posedge clk) begin
    if (coins_load) coins <= coins_load_val;
    else            coins <= coins - cost + revenue;
  end

  // Timeline model: expected outputs after each edge, in an 8-slot ring indexed by edge number
  logic [NREQ-1:0] e_ack  [8];
  logic            e_ok   [8];
  int              e_cost [8];
  int              e_rev  [8];
  logic            e_bd   [8];
  logic            e_dl   [8];
  logic            e_ba   [8];
  logic            e_busy [8];
  logic            e_go   [8];

  int ecount   = 0;
  int m_rr     = 0;
  int m_lives  = 3;
  int m_nxt    = 0;
  int m_over_at = 0;
  bit m_over   = 1'b0;

  function void clr(input int s);
    e_ack[s] = '0; e_ok[s] = 1'b0; e_cost[s] = 0; e_rev[s] = 0;
    e_bd[s] = 1'b0; e_dl[s] = 1'b0; e_ba[s] = 1'b0; e_busy[s] = 1'b0; e_go[s] = 1'b0;
  endfunction

  // Decide what each edge must produce from the rules: who is served, how much, and when the block is free again
  always @(posedge clk) begin
    int n, s, sel, amt, eff, hd;
    bit found, ok;
    n = ecount;
    s = n % 8;
    if (!reset) begin
      for (int k = 0; k < 4; k++) clr((n + k) % 8);
      m_rr = 0; m_lives = 3; m_over = 1'b0; m_nxt = n + 1;
    end else begin
      clr((n + 3) % 8);
      if (m_over && n >= m_over_at) begin
        e_go[s] = 1'b1; e_busy[s] = 1'b1;
      end
      if (n >= m_nxt) begin
        found = 1'b0; sel = 0;
        for (int k = 0; k < NREQ; k++)
          if (!found && req_valid[(m_rr + k) % NREQ]) begin
            found = 1'b1; sel = (m_rr + k) % NREQ;
          end
        if (battle_valid) begin
          e_ba[s] = 1'b1;
          if (m_over) begin
            m_nxt = n + 2;
          end else begin
            e_bd[s] = 1'b1; e_busy[s] = 1'b1;
            if (!battle_win && !battle_tie) begin
              e_dl[s] = 1'b1; m_lives = m_lives - 1;
            end
            if (m_lives == 0) begin
              m_over = 1'b1; m_over_at = n + 1; m_nxt = n + 2;
            end else begin
              hd = 1023 - int'(coins);
              e_rev[(n + 1) % 8]  = (hd < 10) ? hd : 10;
              e_busy[(n + 1) % 8] = 1'b1;
              e_busy[(n + 2) % 8] = 1'b1;
              m_nxt = n + 4;
            end
          end
        end else if (found) begin
          e_ack[s] = 3'(1) << sel;
          m_rr = (sel + 1) % NREQ;
          amt = int'(req_amt[10*sel +: 10]);
          if (m_over) begin
            m_nxt = n + 2;
          end else begin
            e_busy[s] = 1'b1;
            if (req_sell[sel]) begin
              ok = 1'b1;
              eff = (int'(coins) + amt > 1023) ? 1023 - int'(coins) : amt;
            end else if (amt > int'(coins)) begin
              ok = 1'b0; eff = 0;
            end else begin
              ok = 1'b1; eff = amt;
            end
            e_ok[s] = ok;
            if (eff > 0) begin
              if (req_sell[sel]) e_rev[s] = eff;
              else               e_cost[s] = eff;
              e_busy[(n + 1) % 8] = 1'b1;
              m_nxt = n + 3;
            end else begin
              m_nxt = n + 2;
            end
          end
        end
      end
    end
    ecount = ecount + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] rand_amt();
    case ($urandom_range(0, 3))
      0:       return 10'd0;
      1:       return 10'($urandom_range(1, 20));
      2:       return 10'($urandom_range(0, 1023));
      default: return 10'($urandom_range(1, 200));
    endcase
  endfunction

  // One cycle: compare against the model at the falling edge, then act as the requesters
  task automatic tick();
    int s, r;
    @(negedge clk);
    cyc++;
    if (ecount > 0) begin
      s = (ecount - 1) % 8;
      check("req_ack",    int'(req_ack),    int'(e_ack[s]));
      check("req_ok",     int'(req_ok),     int'(e_ok[s]));
      check("cost",       int'(cost),       e_cost[s]);
      check("revenue",    int'(revenue),    e_rev[s]);
      check("battleDone", int'(battleDone), int'(e_bd[s]));
      check("decr_lives", int'(decr_lives), int'(e_dl[s]));
      check("battle_ack", int'(battle_ack), int'(e_ba[s]));
      check("busy",       int'(busy),       int'(e_busy[s]));
      check("game_over",  int'(game_over),  int'(e_go[s]));
    end
    if (decr_lives) cnt_decr++;
    if (revenue != 10'd0 && req_ack == '0) cnt_inc++;
    coins_load = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (req_ack[i]) req_valid[i] = 1'b0;
    if (battle_ack) battle_valid = 1'b0;
    if (rnd_on) begin
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset = 1'b1;
      end else if ((game_over && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        reset = 1'b0; rst_cnt = 2;
        req_valid = '0; battle_valid = 1'b0;
        coins_load = 1'b1; coins_load_val = 10'($urandom_range(0, 1023));
      end else begin
        for (int i = 0; i < NREQ; i++)
          if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_sell[i]  = 1'($urandom_range(0, 1));
            req_amt[10*i +: 10] = rand_amt();
          end
        if (!battle_valid && $urandom_range(0, 15) == 0) begin
          r = $urandom_range(0, 2);
          battle_valid = 1'b1;
          battle_win = (r == 0);
          battle_tie = (r == 1);
        end
      end
    end
  endtask

  task automatic do_reset(input int c);
    reset = 1'b0;
    req_valid = '0; battle_valid = 1'b0; battle_win = 1'b0; battle_tie = 1'b0;
    coins_load = 1'b1; coins_load_val = 10'(c);
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Raise one request and wait (bounded) for its ack; lat = cycles from raise to ack
  task automatic do_req(input int i, input bit sell, input int amt, output int lat);
    req_valid[i] = 1'b1; req_sell[i] = sell; req_amt[10*i +: 10] = 10'(amt);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (req_ack[i]) begin lat = k; break; end
    end
    if (lat < 0) check("req_timeout", 0, 1);
  endtask

  task automatic do_battle(input bit win, input bit tie);
    bit seen;
    seen = 1'b0;
    battle_valid = 1'b1; battle_win = win; battle_tie = tie;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (battle_ack) begin seen = 1'b1; break; end
    end
    if (!seen) check("battle_timeout", 0, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!busy) break;
    end
  endtask

  initial begin
    int lat, when[3];
    int order[$];
    bit saw_back;
    reset = 1'b0; req_valid = '0; req_sell = '0; req_amt = '0;
    battle_valid = 1'b0; battle_win = 1'b0; battle_tie = 1'b0;
    coins_load = 1'b0; coins_load_val = '0;

    // Reset values
    do_reset(10);
    check("rst_ack", int'(req_ack), 0);
    check("rst_cost", int'(cost), 0);
    check("rst_revenue", int'(revenue), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_game_over", int'(game_over), 0);
    tick();

    // coins=10, req0 buy 4
    do_req(0, 1'b0, 4, lat);
    check("buy_latency", lat, 1);
    check("buy_ack", int'(req_ack), 1);
    check("buy_ok", int'(req_ok), 1);
    check("buy_cost", int'(cost), 4);
    tick();
    check("buy_cost_one_cycle", int'(cost), 0);
    tick();
    check("buy_coins", int'(coins), 6);

    // coins=6, req1 buy 7 is denied
    do_req(1, 1'b0, 7, lat);
    check("deny_ack", int'(req_ack), 2);
    check("deny_ok", int'(req_ok), 0);
    check("deny_cost", int'(cost), 0);
    check("deny_revenue", int'(revenue), 0);
    tick();
    tick();
    check("deny_coins", int'(coins), 6);

    // Three simultaneous buys of 1 served in order 0,1,2 three cycles apart
    do_reset(10);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = 1'b1; req_sell[i] = 1'b0; req_amt[10*i +: 10] = 10'd1;
    end
    for (int k = 0; k < 40 && order.size() < 3; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (req_ack[i]) begin order.push_back(i); when[i] = k; end
    end
    check("rr_count", order.size(), 3);
    if (order.size() == 3) begin
      check("rr_first", order[0], 0);
      check("rr_second", order[1], 1);
      check("rr_third", order[2], 2);
      check("rr_gap01", when[1] - when[0], 3);
      check("rr_gap12", when[2] - when[1], 3);
    end
    tick(); tick(); tick();
    check("rr_coins", int'(coins), 7);

    // Sell clipping at the ceiling, then a sell that clips to nothing
    do_reset(1020);
    do_req(0, 1'b1, 9, lat);
    check("sell_revenue", int'(revenue), 3);
    check("sell_ok", int'(req_ok), 1);
    tick(); tick();
    check("sell_coins", int'(coins), 1023);
    tick();
    do_req(2, 1'b1, 5, lat);
    check("sell_full_ok", int'(req_ok), 1);
    check("sell_full_rev", int'(revenue), 0);
    tick();

    // Battle and shop together: battle first, buy checked against post-income coins
    do_reset(5);
    saw_back = 1'b0;
    battle_valid = 1'b1; battle_win = 1'b1; battle_tie = 1'b0;
    req_valid[0] = 1'b1; req_sell[0] = 1'b0; req_amt[9:0] = 10'd12;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (battle_ack) saw_back = 1'b1;
      if (req_ack[0]) begin lat = k; break; end
    end
    check("prio_battle_first", int'(saw_back), 1);
    check("prio_buy_ok", int'(req_ok), 1);
    check("prio_buy_cost", int'(cost), 12);
    tick(); tick();
    check("prio_coins", int'(coins), 3);

    // Three losses end the game
    do_reset(100);
    cnt_decr = 0; cnt_inc = 0;
    do_battle(1'b0, 1'b0);
    do_battle(1'b0, 1'b0);
    do_battle(1'b0, 1'b0);
    check("loss_decr_count", cnt_decr, 3);
    check("loss_income_count", cnt_inc, 2);
    check("loss_game_over", int'(game_over), 1);
    check("loss_coins", int'(coins), 120);
    do_req(0, 1'b0, 1, lat);
    check("over_ack", int'(req_ack), 1);
    check("over_ok", int'(req_ok), 0);
    tick();

    // Random traffic with game-over and mid-transaction resets
    do_reset(int'($urandom_range(0, 1023)));
    rnd_on = 1'b1;
    repeat (4000) tick();
    rnd_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shop_ctrl.md
# shop_ctrl

Transaction and round sequencer for the player stats datapath. It arbitrates shop requests (buy, sell, reroll) from several requesters, checks affordability against the live coin count, and drives the stats block's `cost`/`revenue` inputs. Each amount is presented for exactly one clock cycle. It also turns battle results into `battleDone`/`decr_lives` pulses, grants per-round income, and latches game over.

## Interface
- `NREQ`, default 3: number of shop requesters (2..4).
- `ROUND_INCOME`, default 10: coins granted after every battle that does not end the game.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset; the block is in reset while `reset`=0 at a rising edge of `clk`.
- `req_valid`  in  NREQ  per-requester request; held high and stable until acked.
- `req_sell`  in  NREQ  1 means credit (sell), 0 means debit (buy/reroll).
- `req_amt`  in  10*NREQ  packed amounts; requester i uses bits [10i+9:10i].
- `req_ack`  out  NREQ  one-cycle one-hot completion pulse.
- `req_ok`  out  1  valid with `req_ack`; 1 means applied, 0 means denied.
- `battle_valid`  in  1  battle result available; held until `battle_ack`.
- `battle_win`, `battle_tie`  in  1 each  outcome; neither set means loss.
- `battle_ack`  out  1  one-cycle pulse.
- `coins`  in  10  current coin count from stats.
- `cost`, `revenue`  out  10 each  registered, nonzero for exactly one cycle per transaction.
- `battleDone`, `decr_lives`  out  1 each  registered one-cycle pulses to stats.
- `busy`  out  1  high in any state other than IDLE.
- `game_over`  out  1  sticky until reset.

## Operation
- States: IDLE, APPLY, BATTLE, INCOME, SETTLE, OVER.
- **IDLE:** `battle_valid` has priority over all shop requests.
  - Shop requests are served round-robin. Search starts at `rr_ptr`. The selected index and operation are latched, and `rr_ptr` moves to selected+1 mod NREQ on every grant or deny.
- **Affordability:** evaluated in IDLE against `coins`.
  - Buy with amt > coins is denied.
  - Sell with coins+amt > 1023 is clipped: revenue = 1023−coins (11-bit compare). It is never denied.
  - amt = 0 is acked ok with no coin pulse.
- **APPLY:**
  - Approved buy: `cost`=amt, `revenue`=0.
  - Approved sell: `revenue`=clipped amt, `cost`=0.
  - `req_ack[i]`=1 with `req_ok`.
  - Next state: SETTLE if a nonzero amount was driven, otherwise IDLE.
  - A denied request still passes through APPLY for its ack but drives no coin pulse.
- **BATTLE:**
  - `battleDone`=1 and `battle_ack`=1.
  - On a loss, `decr_lives`=1.
  - If it is a loss and `lives_zero_next` (internal: `lives`==1 sampled in IDLE; `lives` is not a port), go to OVER. Otherwise go to INCOME.
  - Lives are not ported, so loss count is tracked internally: a 2-bit register starts at 3 on reset and decrements on each loss.
- **INCOME:** `revenue`=min(ROUND_INCOME, 1023−coins) for one cycle, then SETTLE.
- **SETTLE:** one idle cycle so the stats counters update before `coins` is sampled again; then IDLE.
- **OVER:**
  - `game_over`=1.
  - All requests are acked with `req_ok`=0, one per visit, still round-robin.
  - `battle_valid` is acked with no pulses.
  - Exits only on reset.
- `cost` and `revenue` are never both nonzero in the same cycle.
- **Reset values:** every output is 0; state IDLE; `rr_ptr`=0; internal lives=3.
- Reset asserted mid-transaction aborts it at that edge. No partial pulse is extended, and the pending requester is not acked and must re-request.

## Timing
- Request seen in IDLE at edge t: ack and coin pulse are in cycle t+1, SETTLE at t+2, next request sampled at t+3. Throughput is one approved transaction per 3 cycles.
- Denied or zero-amount request: ack at t+1, next sample at t+2.
- Battle seen at t: `battleDone`/`decr_lives`/`battle_ack` at t+1, income pulse at t+2, SETTLE at t+3, IDLE at t+4.
- Final loss: OVER from t+2; `game_over` high from t+2.
- Battle and shop request in the same cycle: battle is served first. The shop request stays pending and is served afterwards, with affordability checked against the post-income coins.
- `busy` is combinational from state.

## Test plan
- Reset (`reset`=0 for 2 cycles) -> all outputs 0, `busy`=0, `game_over`=0.
- coins=10; req0 buy amt=4 -> `cost`=4 for exactly one cycle at t+1, `req_ack`=001, `req_ok`=1; coins reads 6 at t+2.
- coins=6; req1 buy amt=7 -> `req_ack`=010, `req_ok`=0, `cost` and `revenue` stay 0; coins unchanged.
- All three requesters assert a buy of amt=1 together with coins=10 -> acks in order 0, 1, 2, three cycles apart; coins ends at 7.
- coins=1020; sell amt=9 -> `revenue`=3; coins=1023.
- Three consecutive losses -> three `decr_lives` pulses; two income pulses of 10; `game_over`=1 after the third; next request is acked with `req_ok`=0.
